mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access (MEM) stage of the five-stage in-order pipeline. Receives the 104-bit EX→MEM bus under the valid/allow_in handshake, issues word loads and stores on the request/response data SRAM interface, and stalls until each access completes. Forwards {pc, final result, dest, gr_we} to WB under the same handshake.

## Interface
Parameters:
- none (bus widths fixed: EX→MEM 104, MEM→WB 70)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- ex_to_mem_valid  in  1  EX holds a valid instruction on to_mem_data
- to_mem_data  in  104  {pc[31:0], alu_result[31:0], rkd_value[31:0], mem_we, res_from_mem, dest[4:0], gr_we}, MSB first
- mem_allow_in  out  1  MEM accepts from EX this cycle
- wb_allow_in  in  1  WB accepts from MEM this cycle
- mem_to_wb_valid  out  1  to_wb_data valid for WB
- to_wb_data  out  70  {pc[31:0], final_result[31:0], dest[4:0], gr_we}
- data_sram_req  out  1  access request
- data_sram_wr  out  1  1 = store, 0 = load
- data_sram_size  out  2  constant 2'b10 (word)
- data_sram_wstrb  out  4  4'hF store, 4'h0 load
- data_sram_addr  out  32  latched alu_result
- data_sram_wdata  out  32  latched rkd_value
- data_sram_addr_ok  in  1  request accepted this cycle
- data_sram_rdata  in  32  read data, valid with data_ok
- data_sram_data_ok  in  1  access complete (loads and stores)
- mem_ale  out  1  misaligned-address flag (see Configuration)

## Operation
- Registers: mem_valid, 104-bit bus latch, rdata_r[31:0], ale_r, state ∈ {IDLE, REQ, WAIT, DONE}.
- Memory op = mem_we | res_from_mem of the latched bus.
- mem_ready_go = (state == DONE); mem_allow_in = ~mem_valid | (mem_ready_go & wb_allow_in); mem_to_wb_valid = mem_valid & mem_ready_go.
- Accept (ex_to_mem_valid & mem_allow_in): latch bus, mem_valid←1, state←REQ if memory op, else DONE.
- Retire without accept (mem_ready_go & wb_allow_in & ~ex_to_mem_valid): mem_valid←0, state←IDLE. Retire and accept in the same cycle: the new instruction's state wins.
- REQ: data_sram_req=1; addr/wr/wstrb/wdata driven from latch and held stable until addr_ok. On addr_ok→WAIT.
- WAIT: req=0. On data_ok: rdata_r←data_sram_rdata (loads), state→DONE.
- DONE: final_result = res_from_mem ? rdata_r : alu_result; held until wb_allow_in.
- data_ok outside WAIT and addr_ok outside REQ are ignored; at most one outstanding access.
- data_sram_req=0 in every state other than REQ.

## Timing
- Reset: mem_valid=0, state=IDLE, bus latch=0, rdata_r=0, ale_r=0 → mem_allow_in=1, mem_to_wb_valid=0, data_sram_req=0, mem_ale=0, to_wb_data=0.
- Instruction first present in MEM at cycle T.
- Non-memory op: mem_to_wb_valid=1 at T (zero added latency).
- Memory op, addr_ok at T, data_ok at T+1: WAIT at T+1, DONE with mem_to_wb_valid=1 at T+2. Each addr_ok/data_ok wait cycle adds one cycle.
- While not DONE, mem_allow_in=0 and EX stalls.
- Reset mid-access (REQ or WAIT): state→IDLE, instruction discarded; a later stray data_ok is ignored.

## Configuration
- MEM_ALE_CHECK_EN defined: memory op with alu_result[1:0] != 2'b00 goes straight from accept to DONE with no SRAM request; ale_r←1; to_wb_data carries gr_we=0; mem_ale = mem_valid & ale_r.
- Not defined: no alignment check; address issued as-is; mem_ale tied to 0; ale_r absent.

## Test plan
- Back-to-back ALU ops (mem_we=0, res_from_mem=0, alu_result=0x1234), wb_allow_in=1 -> mem_to_wb_valid each cycle, final_result=0x1234, data_sram_req never asserted.
- Load alu_result=0x1000, addr_ok at T, data_ok+rdata=0xDEADBEEF at T+1 -> req=1, wr=0, wstrb=0 at T; mem_to_wb_valid at T+2 with final_result=0xDEADBEEF; mem_allow_in=0 at T, T+1.
- Store addr=0x2000, rkd_value=0xA5A5A5A5; addr_ok delayed 3 cycles -> req held with stable addr/wdata and wstrb=4'hF for 4 cycles; DONE one cycle after data_ok; final_result=0x2000.
- Load completed, wb_allow_in=0 for 2 cycles -> to_wb_data and mem_to_wb_valid held; retire and accept next instruction in the same cycle wb_allow_in rises.
- Reset asserted in WAIT, then data_ok pulse -> mem_valid=0, req=0, mem_to_wb_valid stays 0.
- MEM_ALE_CHECK_EN defined, load at 0x1002 -> no req, mem_ale=1 and mem_to_wb_valid=1 at T, gr_we=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: latches the EX->MEM bus, performs one word load/store on the req/ack data SRAM port,
// and forwards {pc, result, dest, gr_we} to WB. Define MEM_ALE_CHECK_EN to trap misaligned accesses.
module mem_access_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ex_to_mem_valid,
    input  logic [103:0] to_mem_data,
    output logic         mem_allow_in,
    input  logic         wb_allow_in,
    output logic         mem_to_wb_valid,
    output logic [69:0]  to_wb_data,
    output logic         data_sram_req,
    output logic         data_sram_wr,
    output logic [1:0]   data_sram_size,
    output logic [3:0]   data_sram_wstrb,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    input  logic         data_sram_addr_ok,
    input  logic [31:0]  data_sram_rdata,
    input  logic         data_sram_data_ok,
    output logic         mem_ale
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic          mem_valid_q, mem_valid_d;
    logic [103:0]  bus_q, bus_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   pc, alu_result, rkd_value, final_result;
    logic          mem_we, res_from_mem, gr_we, wb_gr_we;
    logic [4:0]    dest;
    logic          mem_ready_go, accept, retire;
    logic          in_mem_op, in_misaligned;

    assign {pc, alu_result, rkd_value, mem_we, res_from_mem, dest, gr_we} = bus_q;

    assign in_mem_op    = to_mem_data[7] | to_mem_data[6];
    assign mem_ready_go = (state_q == StDone);
    assign mem_allow_in = ~mem_valid_q | (mem_ready_go & wb_allow_in);
    assign accept       = ex_to_mem_valid & mem_allow_in;
    assign retire       = mem_ready_go & wb_allow_in;

`ifdef MEM_ALE_CHECK_EN
    logic ale_q, ale_d;

    assign in_misaligned = in_mem_op & (to_mem_data[41:40] != 2'b00);
    assign ale_d         = accept ? in_misaligned : ale_q;
    assign mem_ale       = mem_valid_q & ale_q;
    // A trapped access must not write the register file.
    assign wb_gr_we      = gr_we & ~ale_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ale_q <= 1'b0;
        end else begin
            ale_q <= ale_d;
        end
    end
`else
    assign in_misaligned = 1'b0;
    assign mem_ale       = 1'b0;
    assign wb_gr_we      = gr_we;
`endif

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        bus_d       = bus_q;
        rdata_d     = rdata_q;

        unique case (state_q)
            StReq: begin
                if (data_sram_addr_ok) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (data_sram_data_ok) begin
                    state_d = StDone;
                    if (res_from_mem) begin
                        rdata_d = data_sram_rdata;
                    end
                end
            end
            default: ;
        endcase

        if (retire) begin
            mem_valid_d = 1'b0;
            state_d     = StIdle;
        end

        // A newly accepted instruction overrides the retirement above.
        if (accept) begin
            bus_d       = to_mem_data;
            mem_valid_d = 1'b1;
            state_d     = (in_mem_op & ~in_misaligned) ? StReq : StDone;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mem_valid_q <= 1'b0;
            bus_q       <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            bus_q       <= bus_d;
            rdata_q     <= rdata_d;
        end
    end

    assign data_sram_req   = (state_q == StReq);
    assign data_sram_wr    = mem_we;
    assign data_sram_size  = 2'b10;
    assign data_sram_wstrb = mem_we ? 4'hF : 4'h0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

    assign final_result    = res_from_mem ? rdata_q : alu_result;
    assign mem_to_wb_valid = mem_valid_q & mem_ready_go;
    assign to_wb_data      = {pc, final_result, dest, wb_gr_we};

endmodule
